// File: rtl/barrel_shift_pipe.sv
// ============================================================================
// barrel_shift_pipe : SHW-stage pipelined rotate/shift unit with ready/valid
// Rev 1.0
// ============================================================================
`default_nettype none

module barrel_shift_pipe #(
  parameter int WIDTH = 8,
  parameter int SHW   = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic [SHW-1:0]   in_amt,
  input  logic [1:0]       in_mode,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic [15:0]      xfer_cnt
);

  localparam logic [1:0] MODE_ROR = 2'b00;
  localparam logic [1:0] MODE_ROL = 2'b01;
  localparam logic [1:0] MODE_LSR = 2'b10;

  logic [WIDTH-1:0] st_data [SHW];
  logic [SHW-1:0]   st_amt  [SHW];
  logic [1:0]       st_mode [SHW];
  logic             st_vld  [SHW];
  logic             advance;

  // One fixed-distance step; the arithmetic fill uses the current MSB, which
  // every earlier arithmetic step has preserved as the original sign bit.
  function automatic logic [WIDTH-1:0] step(input logic [WIDTH-1:0] d,
                                            input logic [1:0] mode,
                                            input int s);
    logic [WIDTH-1:0] r;
    r = '0;
    for (int i = 0; i < WIDTH; i++) begin
      case (mode)
        MODE_ROR: r[i] = d[(i + s) % WIDTH];
        MODE_ROL: r[i] = d[(i + WIDTH - s) % WIDTH];
        MODE_LSR: r[i] = (i + s < WIDTH) ? d[(i + s) % WIDTH] : 1'b0;
        default:  r[i] = (i + s < WIDTH) ? d[(i + s) % WIDTH] : d[WIDTH-1];
      endcase
    end
    return r;
  endfunction

  assign out_valid = st_vld[SHW-1];
  assign out_data  = st_data[SHW-1];
  assign advance   = !out_valid || out_ready;
  assign in_ready  = advance;

  for (genvar k = 0; k < SHW; k++) begin : g_stage
    logic [WIDTH-1:0] src_data;
    logic [SHW-1:0]   src_amt;
    logic [1:0]       src_mode;
    logic             src_vld;

    if (k == 0) begin : g_head
      assign src_data = in_data;
      assign src_amt  = in_amt;
      assign src_mode = in_mode;
      assign src_vld  = in_valid;
    end else begin : g_body
      assign src_data = st_data[k-1];
      assign src_amt  = st_amt[k-1];
      assign src_mode = st_mode[k-1];
      assign src_vld  = st_vld[k-1];
    end

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        st_vld[k]  <= 1'b0;
        st_data[k] <= '0;
        st_amt[k]  <= '0;
        st_mode[k] <= '0;
      end else if (advance) begin
        st_vld[k] <= src_vld;
        // Payload only moves with a valid op; bubbles leave it untouched.
        if (src_vld) begin
          st_data[k] <= src_amt[k] ? step(src_data, src_mode, 1 << k) : src_data;
          st_amt[k]  <= src_amt;
          st_mode[k] <= src_mode;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      xfer_cnt <= '0;
    end else if (out_valid && out_ready) begin
      xfer_cnt <= xfer_cnt + 16'd1;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_barrel_shift_pipe.sv
// ============================================================================
// tb_barrel_shift_pipe : directed vector table plus multi-cycle sequences
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_barrel_shift_pipe;

  logic       clk;
  logic       rst_n;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] in_data;
  logic [2:0] in_amt;
  logic [1:0] in_mode;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] out_data;
  logic [15:0] xfer_cnt;

  int n_vec = 0;
  int n_bad = 0;

  barrel_shift_pipe #(.WIDTH(8)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_amt    (in_amt),
    .in_mode   (in_mode),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .xfer_cnt  (xfer_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] data;
    logic [2:0] amt;
    logic [1:0] mode;
    logic [7:0] exp;
  } vec_t;

  vec_t vecs [15];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic pulse_reset();
    rst_n = 1'b0;
    #2;
    rst_n = 1'b1;
  endtask

  // Single op: accepted on edge n, absent after n+1, present after n+2.
  task automatic run_op(input int idx);
    in_valid = 1'b1;
    in_data  = vecs[idx].data;
    in_amt   = vecs[idx].amt;
    in_mode  = vecs[idx].mode;
    check($sformatf("vec%0d in_ready", idx), in_ready, 1'b1);
    tick();
    in_valid = 1'b0;
    in_data  = 8'($urandom);
    in_mode  = 2'($urandom);
    tick();
    check($sformatf("vec%0d early valid", idx), out_valid, 1'b0);
    tick();
    check($sformatf("vec%0d out_valid", idx), out_valid, 1'b1);
    check($sformatf("vec%0d out_data", idx), out_data, vecs[idx].exp);
    tick();
  endtask

  initial begin
    int hs;
    int stale;
    logic [7:0] exp_q [4];

    vecs[0]  = '{8'h96, 3'd3, 2'b00, 8'hD2};
    vecs[1]  = '{8'h96, 3'd3, 2'b01, 8'hB4};
    vecs[2]  = '{8'h96, 3'd3, 2'b10, 8'h12};
    vecs[3]  = '{8'h96, 3'd3, 2'b11, 8'hF2};
    vecs[4]  = '{8'hA5, 3'd0, 2'b00, 8'hA5};
    vecs[5]  = '{8'hA5, 3'd0, 2'b01, 8'hA5};
    vecs[6]  = '{8'hA5, 3'd0, 2'b10, 8'hA5};
    vecs[7]  = '{8'hA5, 3'd0, 2'b11, 8'hA5};
    vecs[8]  = '{8'h80, 3'd7, 2'b11, 8'hFF};
    vecs[9]  = '{8'h01, 3'd1, 2'b00, 8'h80};
    vecs[10] = '{8'h80, 3'd1, 2'b01, 8'h01};
    vecs[11] = '{8'h80, 3'd7, 2'b10, 8'h01};
    vecs[12] = '{8'h7F, 3'd2, 2'b11, 8'h1F};
    vecs[13] = '{8'hA5, 3'd4, 2'b00, 8'h5A};
    vecs[14] = '{8'h96, 3'd5, 2'b01, 8'hD2};

    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_data   = 8'h00;
    in_amt    = 3'd0;
    in_mode   = 2'b00;
    out_ready = 1'b1;
    #1;
    check("reset out_valid", out_valid, 1'b0);
    check("reset out_data", out_data, 8'h00);
    check("reset xfer_cnt", xfer_cnt, 16'h0000);
    tick();
    tick();
    rst_n = 1'b1;
    tick();
    check("post-reset in_ready", in_ready, 1'b1);

    for (int i = 0; i < 15; i++) run_op(i);

    // Back-to-back: results on consecutive cycles, first after edge n+2.
    pulse_reset();
    tick();
    for (int c = 0; c < 8; c++) begin
      if (c < 4) begin
        in_valid = 1'b1;
        in_data  = 8'h01 << c;
        in_amt   = 3'd1;
        in_mode  = 2'b01;
      end else begin
        in_valid = 1'b0;
      end
      tick();
      if (c >= 2 && c < 6) begin
        check($sformatf("thru valid c%0d", c), out_valid, 1'b1);
        check($sformatf("thru data c%0d", c), out_data, 8'h02 << (c - 2));
      end
    end
    check("thru xfer_cnt", xfer_cnt, 16'd4);
    check("thru drained", out_valid, 1'b0);

    // Backpressure with a full pipeline and a fourth op waiting.
    pulse_reset();
    tick();
    out_ready = 1'b0;
    exp_q = '{8'h06, 8'h0A, 8'h12, 8'h22};
    for (int c = 0; c < 3; c++) begin
      in_valid = 1'b1;
      in_data  = (c == 0) ? 8'h03 : (c == 1) ? 8'h05 : 8'h09;
      in_amt   = 3'd1;
      in_mode  = 2'b01;
      tick();
    end
    in_data = 8'h11;
    for (int c = 0; c < 5; c++) begin
      check($sformatf("bp in_ready c%0d", c), in_ready, 1'b0);
      check($sformatf("bp out_valid c%0d", c), out_valid, 1'b1);
      check($sformatf("bp out_data c%0d", c), out_data, exp_q[0]);
      tick();
    end
    out_ready = 1'b1;
    #1;
    check("bp release in_ready", in_ready, 1'b1);
    tick();
    in_valid = 1'b0;
    for (int c = 1; c < 4; c++) begin
      check($sformatf("bp drain valid %0d", c), out_valid, 1'b1);
      check($sformatf("bp drain data %0d", c), out_data, exp_q[c]);
      tick();
    end
    check("bp empty", out_valid, 1'b0);
    check("bp xfer_cnt", xfer_cnt, 16'd4);

    // Reset with three ops in flight.
    for (int c = 0; c < 3; c++) begin
      in_valid = 1'b1;
      in_data  = 8'hC0 | 8'(c);
      in_amt   = 3'd2;
      in_mode  = 2'b00;
      tick();
    end
    in_valid = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    check("midrst out_valid", out_valid, 1'b0);
    check("midrst xfer_cnt", xfer_cnt, 16'h0000);
    check("midrst out_data", out_data, 8'h00);
    #2;
    rst_n = 1'b1;
    stale = 0;
    for (int c = 0; c < 6; c++) begin
      tick();
      if (out_valid) stale++;
    end
    check("midrst stale results", stale, 0);
    check("midrst xfer_cnt after", xfer_cnt, 16'h0000);

    // Counter wrap after 65536 handshakes.
    hs = 0;
    out_ready = 1'b1;
    in_valid  = 1'b1;
    in_data   = 8'h5A;
    in_amt    = 3'd0;
    for (int c = 0; c < 70000 && hs < 65536; c++) begin
      if (out_valid && out_ready) hs++;
      tick();
      if (hs == 65535 && out_valid && out_ready) check("wrap at ffff", xfer_cnt, 16'hFFFF);
    end
    in_valid = 1'b0;
    check("wrap handshakes", hs, 65536);
    check("wrap xfer_cnt", xfer_cnt, 16'h0000);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

`default_nettype wire
